redmule_cfg_dispatcher: RTL and testbench

// Master-side initiator on the HWPE peripheral config port: takes a complete RedMulE job descriptor from a

---
 rtl/redmule_pkg.sv | 29 ++
 rtl/redmule_cfg_dispatcher.sv | 208 ++++++++++++++++++++
 tb/tb_redmule_cfg_dispatcher.sv | 563 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/redmule_pkg.sv
// Shared constants and types for the RedMulE config-port dispatcher:
// register offsets on the accelerator slave port and the dispatcher FSM states.
package redmule_pkg;

    localparam int unsigned REDMULE_REGS = 6;

    localparam logic [31:0] TRIGGER_OFFS    = 32'h00;
    localparam logic [31:0] ACQUIRE_OFFS    = 32'h04;
    localparam logic [31:0] SOFT_CLEAR_OFFS = 32'h14;
    localparam logic [31:0] JOB_BASE        = 32'h40;

    typedef enum logic [3:0] {
        IDLE,
        ACQ_REQ,
        ACQ_RSP,
        BACKOFF,
        WR_REGS,
        TRIG,
        WAIT_EVT,
        SCLR,
        DONE
    } dispatch_state_e;

    // Byte address of job register idx.
    function automatic logic [31:0] job_reg_addr(input logic [31:0] idx);
        return JOB_BASE + (idx << 2);
    endfunction

endpackage

// File: rtl/redmule_cfg_dispatcher.sv
// Config-port master: acquires a RedMulE context, writes the job registers, triggers and waits for completion.
// Optional REDMULE_DISPATCH_TIMEOUT_EN adds a completion watchdog that soft-clears the accelerator.
module redmule_cfg_dispatcher
    import redmule_pkg::*;
#(
    parameter int unsigned NumRegs    = REDMULE_REGS,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned BackoffCyc = 16,
    parameter int unsigned TimeoutCyc = 2**20
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [NumRegs*32-1:0]   job_regs_i,
    output logic                    periph_req_o,
    input  logic                    periph_gnt_i,
    output logic [31:0]             periph_add_o,
    output logic                    periph_wen_o,
    output logic [3:0]              periph_be_o,
    output logic [31:0]             periph_data_o,
    output logic [ID_WIDTH-1:0]     periph_id_o,
    input  logic [31:0]             periph_r_data_i,
    input  logic                    periph_r_valid_i,
    input  logic                    evt_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [7:0]              job_id_o,
    output logic                    err_o,
    output logic [3:0]              state_o
);

    // Config port: a request keeps req/add/wen/data stable until gnt and retires on the gnt
    // cycle; read data returns with r_valid no earlier than the cycle after gnt, and no new
    // request is raised while that read is outstanding (ACQ_RSP drives req low).

    localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int unsigned BoW  = (BackoffCyc > 1) ? $clog2(BackoffCyc) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);
    localparam logic [BoW-1:0]  LastBo  = BoW'(BackoffCyc - 1);

    dispatch_state_e state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [BoW-1:0]  bo_q, bo_d;
    logic [7:0]      job_id_q, job_id_d;
    logic [31:0]     regs_q [NumRegs];
    logic            accept;
    logic            timeout;

    assign job_ready_o = (state_q == IDLE) && !clear_i;
    assign accept      = job_valid_i && job_ready_o;

    // Descriptor storage is plain data; it is only meaningful after an accept.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            for (int k = 0; k < NumRegs; k++) begin
                regs_q[k] <= job_regs_i[32*k +: 32];
            end
        end
    end

`ifdef REDMULE_DISPATCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCyc + 1);
    logic [TW-1:0] tcnt_q;
    logic          err_q;

    // Counter is held at zero outside WAIT_EVT, so every wait starts from zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q <= '0;
        end else if (clear_i || state_q != WAIT_EVT) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clear_i || accept) begin
            err_q <= 1'b0;
        end else if (state_q == SCLR && periph_gnt_i) begin
            err_q <= 1'b1;
        end
    end

    assign timeout = (state_q == WAIT_EVT) && (tcnt_q == TW'(TimeoutCyc - 1));
    assign err_o   = err_q;
`else
    localparam int unsigned unused_timeout_cyc = TimeoutCyc;
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bo_q     <= '0;
            job_id_q <= '0;
        end else if (clear_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bo_q     <= '0;
            job_id_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bo_q     <= bo_d;
            job_id_q <= job_id_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bo_d     = bo_q;
        job_id_d = job_id_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACQ_REQ;
            end
            ACQ_REQ: begin
                if (periph_gnt_i) state_d = ACQ_RSP;
            end
            ACQ_RSP: begin
                // Bit 31 of the acquire read flags "no free context".
                if (periph_r_valid_i) begin
                    if (periph_r_data_i[31]) begin
                        state_d = BACKOFF;
                        bo_d    = '0;
                    end else begin
                        job_id_d = periph_r_data_i[7:0];
                        idx_d    = '0;
                        state_d  = WR_REGS;
                    end
                end
            end
            BACKOFF: begin
                if (bo_q == LastBo) state_d = ACQ_REQ;
                else                bo_d    = bo_q + BoW'(1);
            end
            WR_REGS: begin
                if (periph_gnt_i) begin
                    if (idx_q == LastIdx) state_d = TRIG;
                    else                  idx_d   = idx_q + IdxW'(1);
                end
            end
            TRIG: begin
                if (periph_gnt_i) state_d = WAIT_EVT;
            end
            WAIT_EVT: begin
                if (evt_i)        state_d = DONE;
                else if (timeout) state_d = SCLR;
            end
            SCLR: begin
                if (periph_gnt_i) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        periph_req_o  = 1'b0;
        periph_add_o  = '0;
        periph_wen_o  = 1'b1;
        periph_data_o = '0;
        case (state_q)
            ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = ACQUIRE_OFFS;
            end
            WR_REGS: begin
                periph_req_o  = 1'b1;
                periph_add_o  = job_reg_addr(32'(idx_q));
                periph_wen_o  = 1'b0;
                periph_data_o = regs_q[idx_q];
            end
            TRIG: begin
                periph_req_o = 1'b1;
                periph_add_o = TRIGGER_OFFS;
                periph_wen_o = 1'b0;
            end
            SCLR: begin
                periph_req_o = 1'b1;
                periph_add_o = SOFT_CLEAR_OFFS;
                periph_wen_o = 1'b0;
            end
            default: ;
        endcase
    end

    logic unused_rdata;
    assign unused_rdata = ^periph_r_data_i[30:8];

    assign periph_be_o = 4'hF;
    assign periph_id_o = '0;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign job_id_o    = job_id_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_redmule_cfg_dispatcher.sv
// Directed bench for redmule_cfg_dispatcher; exercises the watchdog path when
// REDMULE_DISPATCH_TIMEOUT_EN is defined, otherwise checks that WAIT_EVT never times out.
module tb_redmule_cfg_dispatcher;
    import redmule_pkg::*;

    localparam int unsigned NR = REDMULE_REGS;
    localparam int unsigned BO = 16;
    localparam int unsigned TO = 100;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic              clear_i = 1'b0;
    logic              job_valid_i = 1'b0;
    logic              job_ready_o;
    logic [NR*32-1:0]  job_regs_i = '0;
    logic              periph_req_o;
    logic              periph_gnt_i = 1'b1;
    logic [31:0]       periph_add_o;
    logic              periph_wen_o;
    logic [3:0]        periph_be_o;
    logic [31:0]       periph_data_o;
    logic [7:0]        periph_id_o;
    logic [31:0]       periph_r_data_i = '0;
    logic              periph_r_valid_i = 1'b0;
    logic              evt_i = 1'b0;
    logic              busy_o, done_o, err_o;
    logic [7:0]        job_id_o;
    logic [3:0]        state_o;

    redmule_cfg_dispatcher #(
        .NumRegs(NR), .ID_WIDTH(8), .BackoffCyc(BO), .TimeoutCyc(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_regs_i(job_regs_i),
        .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
        .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
        .periph_id_o(periph_id_o), .periph_r_data_i(periph_r_data_i),
        .periph_r_valid_i(periph_r_valid_i), .evt_i(evt_i), .busy_o(busy_o), .done_o(done_o),
        .job_id_o(job_id_o), .err_o(err_o), .state_o(state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- slave model / monitor ----------------
    logic [64:0] exp_q[$];
    logic [64:0] obs_q[$];
    logic [31:0] acq_q[$];
    int          rd_cyc_q[$];
    bit          gnt_random = 0;
    bit          rd_pending = 0;
    bit          stray_evt = 0;
    int          evt_dly = 10;
    int          evt_cnt = 0;
    int          trig_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (rst_ni && periph_req_o && periph_gnt_i) begin
            obs_q.push_back({periph_wen_o, periph_add_o, periph_wen_o ? 32'h0 : periph_data_o});
            if (periph_wen_o) begin
                rd_pending = 1;
                rd_cyc_q.push_back(cyc);
            end else if (periph_add_o == TRIGGER_OFFS) begin
                trig_cyc = cyc;
                if (evt_dly > 0) evt_cnt = evt_dly;
            end
        end
        if (rst_ni && done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    always @(posedge clk) begin
        #1;
        periph_gnt_i = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_pending) begin
            periph_r_valid_i = 1'b1;
            periph_r_data_i  = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
            rd_pending = 0;
        end else begin
            periph_r_valid_i = 1'b0;
            periph_r_data_i  = 32'h0;
        end
        if (evt_cnt > 0) begin
            evt_cnt--;
            evt_i = (evt_cnt == 0);
        end else begin
            evt_i = stray_evt;
            stray_evt = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic flush();
        exp_q.delete();
        obs_q.delete();
        rd_cyc_q.delete();
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        flush();
    endtask

    task automatic push_job_exp(input logic [31:0] base, input logic [31:0] step);
        for (int k = 0; k < NR; k++)
            exp_q.push_back({1'b0, JOB_BASE + 32'(4*k), base + step * 32'(k)});
        exp_q.push_back({1'b0, TRIGGER_OFFS, 32'h0});
    endtask

    // Presents a descriptor for one accept, then scrambles the inputs.
    task automatic send_job(input logic [31:0] base, input logic [31:0] step, output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (job_ready_o) ok = 1;
        end
        if (ok) begin
            for (int k = 0; k < NR; k++) job_regs_i[32*k +: 32] = base + step * 32'(k);
            job_valid_i = 1'b1;
            @(negedge clk);
            job_valid_i = 1'b0;
            job_regs_i = {NR{32'hDEAD_BEEF}};
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (done_o) ok = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_dut();
        @(negedge clk);
        tests_run++;
        if ({periph_req_o, periph_wen_o, busy_o, done_o, err_o} !== 5'b01000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got req/wen/busy/done/err=%b want 01000",
                     {periph_req_o, periph_wen_o, busy_o, done_o, err_o});
        end
        tests_run++;
        if (periph_add_o !== 32'h0 || periph_data_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_addr_data: got add=%h data=%h want 0/0", periph_add_o, periph_data_o);
        end
        tests_run++;
        if (job_id_o !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_job_id: got %h want 00", job_id_o);
        end
        tests_run++;
        if (job_ready_o !== 1'b1 || state_o !== 4'(IDLE)) begin
            tests_failed++;
            $display("FAIL reset_idle: got ready=%b state=%0d want 1/%0d", job_ready_o, state_o, IDLE);
        end
        tests_run++;
        if (periph_be_o !== 4'hF || periph_id_o !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_be_id: got be=%h id=%h want f/00", periph_be_o, periph_id_o);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        gnt_random = 0; evt_dly = 10; flush();
        acq_q.push_back(32'h3);
        d0 = done_cnt;
        exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'hA000_0000, 32'h1);
        send_job(32'hA000_0000, 32'h1, ok);
        if (ok) wait_done(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL basic_done: no done_o within budget"); end
        repeat (2) @(negedge clk);
        tests_run++;
        if (done_cnt - d0 != 1) begin
            tests_failed++;
            $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0);
        end
        tests_run++;
        if (job_id_o !== 8'd3 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_id_busy: got id=%0d busy=%b want 3/0", job_id_o, busy_o);
        end
        tests_run++;
        if (done_cyc - trig_cyc != 11) begin
            tests_failed++;
            $display("FAIL basic_evt_latency: got %0d want 11", done_cyc - trig_cyc);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL basic_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL basic_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backoff();
        bit ok;
        gnt_random = 0; evt_dly = 10; flush();
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'hFFFF_FFFF);
        acq_q.push_back(32'h0);
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'hB000_0000, 32'h10);
        send_job(32'hB000_0000, 32'h10, ok);
        if (ok) wait_done(400, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL backoff_done: no done_o within budget"); end
        @(negedge clk);
        tests_run++;
        if (rd_cyc_q.size() != 3) begin
            tests_failed++;
            $display("FAIL backoff_reads: got %0d want 3", rd_cyc_q.size());
        end
        // read grant, one response cycle, BO idle cycles, then the retry request
        for (int i = 1; i < rd_cyc_q.size(); i++) begin
            tests_run++;
            if (rd_cyc_q[i] - rd_cyc_q[i-1] != BO + 2) begin
                tests_failed++;
                $display("FAIL backoff_gap%0d: got %0d want %0d", i, rd_cyc_q[i] - rd_cyc_q[i-1], BO + 2);
            end
        end
        tests_run++;
        if (job_id_o !== 8'd0) begin
            tests_failed++;
            $display("FAIL backoff_job_id: got %0d want 0", job_id_o);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL backoff_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL backoff_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_gnt_stalls();
        bit ok;
        bit seen = 0;
        bit prev_stall = 0;
        logic [64:0] prev = '0;
        logic [64:0] cur;
        gnt_random = 1; evt_dly = 10; flush();
        acq_q.push_back(32'h7);
        exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'h5500_0000, 32'h3);
        send_job(32'h5500_0000, 32'h3, ok);
        for (int i = 0; i < 600 && ok && !seen; i++) begin
            @(negedge clk);
            cur = {periph_wen_o, periph_add_o, periph_data_o};
            if (prev_stall) begin
                tests_run++;
                if (periph_req_o !== 1'b1 || cur !== prev) begin
                    tests_failed++;
                    $display("FAIL stall_stable: got req=%b %h want 1 %h", periph_req_o, cur, prev);
                end
            end
            prev_stall = periph_req_o && !periph_gnt_i;
            prev = cur;
            if (done_o) seen = 1;
        end
        gnt_random = 0;
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL stall_done: no done_o within budget"); end
        @(negedge clk);
        tests_run++;
        if (job_id_o !== 8'd7) begin
            tests_failed++;
            $display("FAIL stall_job_id: got %0d want 7", job_id_o);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL stall_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL stall_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_clear();
        bit ok;
        bit hit = 0;
        int d0;
        gnt_random = 0; evt_dly = 10; flush();
        acq_q.push_back(32'h5);
        d0 = done_cnt;
        send_job(32'hC000_0000, 32'h1, ok);
        for (int i = 0; i < 50 && ok && !hit; i++) begin
            @(negedge clk);
            if (periph_req_o && periph_add_o == JOB_BASE + 32'h8) hit = 1;
        end
        tests_run++;
        if (!hit) begin tests_failed++; $display("FAIL clear_reach_idx2: write to 0x48 never seen"); end
        clear_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (periph_req_o !== 1'b0 || busy_o !== 1'b0 || state_o !== 4'(IDLE)) begin
            tests_failed++;
            $display("FAIL clear_abort: got req=%b busy=%b state=%0d want 0/0/%0d",
                     periph_req_o, busy_o, state_o, IDLE);
        end
        tests_run++;
        if (job_ready_o !== 1'b0 || job_id_o !== 8'h0) begin
            tests_failed++;
            $display("FAIL clear_ready_id: got ready=%b id=%0d want 0/0", job_ready_o, job_id_o);
        end
        clear_i = 1'b0;
        @(negedge clk);
        tests_run++;
        if (done_cnt != d0) begin
            tests_failed++;
            $display("FAIL clear_no_done: got %0d pulses want 0", done_cnt - d0);
        end
        flush();
        acq_q.delete();
        acq_q.push_back(32'h9);
        exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'hD000_0000, 32'h100);
        send_job(32'hD000_0000, 32'h100, ok);
        if (ok) wait_done(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL clear_rejob_done: no done_o within budget"); end
        @(negedge clk);
        tests_run++;
        if (job_id_o !== 8'd9) begin
            tests_failed++;
            $display("FAIL clear_rejob_id: got %0d want 9", job_id_o);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL clear_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL clear_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stray_evt();
        bit ok;
        bit hit = 0;
        int d0;
        gnt_random = 0; evt_dly = 10; flush();
        d0 = done_cnt;
        stray_evt = 1;
        repeat (4) @(negedge clk);
        tests_run++;
        if (done_cnt != d0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_idle: got pulses=%0d busy=%b want 0/0", done_cnt - d0, busy_o);
        end
        acq_q.push_back(32'h2);
        send_job(32'hE000_0000, 32'h2, ok);
        for (int i = 0; i < 50 && ok && !hit; i++) begin
            @(negedge clk);
            if (periph_req_o && periph_add_o == JOB_BASE + 32'h4) hit = 1;
        end
        stray_evt = 1;
        wait_done(200, ok);
        tests_run++;
        if (!ok || !hit) begin tests_failed++; $display("FAIL stray_done: got done=%b hit=%b want 1/1", ok, hit); end
        @(negedge clk);
        tests_run++;
        if (done_cyc - trig_cyc != 11 || done_cnt - d0 != 1) begin
            tests_failed++;
            $display("FAIL stray_wr_regs: got latency=%0d pulses=%0d want 11/1",
                     done_cyc - trig_cyc, done_cnt - d0);
        end
    endtask

`ifdef REDMULE_DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        gnt_random = 0; evt_dly = 0; flush();
        acq_q.push_back(32'h4);
        exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'hF000_0000, 32'h1);
        exp_q.push_back({1'b0, SOFT_CLEAR_OFFS, 32'h0});
        send_job(32'hF000_0000, 32'h1, ok);
        if (ok) wait_done(400, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL timeout_done: no done_o within budget"); end
        tests_run++;
        if (err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_err: got %b want 1", err_o);
        end
        @(negedge clk);
        tests_run++;
        if (done_cyc - trig_cyc != TO + 2) begin
            tests_failed++;
            $display("FAIL timeout_latency: got %0d want %0d", done_cyc - trig_cyc, TO + 2);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL timeout_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL timeout_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        evt_dly = 10;
        acq_q.push_back(32'h1);
        send_job(32'h1000_0000, 32'h1, ok);
        tests_run++;
        if (!ok || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_err_clear: got accepted=%b err=%b want 1/0", ok, err_o);
        end
        wait_done(200, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL timeout_next_done: no done_o within budget"); end
    endtask
`else
    task automatic test_no_timeout();
        bit ok;
        int d0;
        int sclr = 0;
        gnt_random = 0; evt_dly = 0; flush();
        acq_q.push_back(32'h4);
        d0 = done_cnt;
        send_job(32'hF000_0000, 32'h1, ok);
        repeat (3 * TO) @(negedge clk);
        foreach (obs_q[i]) if (obs_q[i][63:32] == SOFT_CLEAR_OFFS) sclr++;
        tests_run++;
        if (!ok || state_o !== 4'(WAIT_EVT) || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL notimeout_wait: got state=%0d busy=%b want %0d/1", state_o, busy_o, WAIT_EVT);
        end
        tests_run++;
        if (err_o !== 1'b0 || done_cnt != d0 || sclr != 0) begin
            tests_failed++;
            $display("FAIL notimeout_quiet: got err=%b pulses=%0d sclr=%0d want 0/0/0",
                     err_o, done_cnt - d0, sclr);
        end
        evt_dly = 10;
        stray_evt = 1;
        wait_done(20, ok);
        tests_run++;
        if (!ok || err_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL notimeout_evt_done: got done=%b err=%b want 1/0", ok, err_o);
        end
    endtask
`endif

    task automatic test_back_to_back();
        bit ok;
        gnt_random = 0; evt_dly = 10; flush();
        acq_q.push_back(32'h6);
        acq_q.push_back(32'h8);
        send_job(32'h2000_0000, 32'h1, ok);
        if (ok) wait_done(200, ok);
        tests_run++;
        if (!ok || job_ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_first: got done=%b ready=%b want 1/0", ok, job_ready_o);
        end
        flush();
        exp_q.push_back({1'b1, ACQUIRE_OFFS, 32'h0});
        push_job_exp(32'h3000_0000, 32'h4);
        for (int k = 0; k < NR; k++) job_regs_i[32*k +: 32] = 32'h3000_0000 + 32'h4 * 32'(k);
        job_valid_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (job_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready_after_done: got %b want 1", job_ready_o);
        end
        @(negedge clk);
        job_valid_i = 1'b0;
        job_regs_i = {NR{32'hDEAD_BEEF}};
        tests_run++;
        if (state_o !== 4'(ACQ_REQ) || busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_accept: got state=%0d busy=%b want %0d/1", state_o, busy_o, ACQ_REQ);
        end
        wait_done(200, ok);
        @(negedge clk);
        tests_run++;
        if (!ok || job_id_o !== 8'd8) begin
            tests_failed++;
            $display("FAIL b2b_second: got done=%b id=%0d want 1/8", ok, job_id_o);
        end
        tests_run++;
        if (obs_q.size() != exp_q.size()) begin
            tests_failed++;
            $display("FAIL b2b_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            tests_run++;
            if (obs_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_txn%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_backoff();
        test_gnt_stalls();
        test_clear();
        test_stray_evt();
`ifdef REDMULE_DISPATCH_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
